dreg_share_arbiter: RTL and testbench

Round-robin arbiter and write sequencer for one shared WIDTH-bit positive-edge D register, with complementary Q and Qbar outputs. Four requesters compete to load the register. The block grants one requester at a time using a req/grant four-phase handshake. It then clocks the winner's data into the register and releases ownership only after the winner drops its request. It sits between the requesting datapath blocks and the shared storage element, and is the only writer of that register.

---
 rtl/dreg_share_arbiter.sv | 120 ++++++++++++
 tb/tb_dreg_share_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dreg_share_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Four requesters use a req/grant four-phase handshake. The winner's data is
// loaded in the single GRANT cycle. Ownership is released once the winner
// drops its request.
module dreg_share_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   wr_data,
    output logic [3:0]           grant,
    output logic [1:0]           owner,
    output logic                 busy,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qbar
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDXW = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  qbar_q, qbar_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic              found;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  owner_data;

    // Data word of the current owner
    assign owner_data = wr_data[int'(owner_q)*int'(WIDTH) +: WIDTH];

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            q_q     <= '0;
            qbar_q  <= '1;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
            qbar_q  <= qbar_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state: rotating-priority scan in IDLE, load in GRANT, wait in RELEASE
    always_comb begin
        state_d = state_q;
        grant_d = '0;
        owner_d = owner_q;
        busy_d  = busy_q;
        q_d     = q_q;
        qbar_d  = qbar_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = '0;

        case (state_q)
            IDLE: begin
                for (int k = 0; k < int'(NREQ); k++) begin
                    idx = ptr_q + IDXW'(k);
                    if (!found && req[idx]) begin
                        found   = 1'b1;
                        owner_d = idx;
                    end
                end
                if (found) begin
                    state_d = GRANT;
                    grant_d = NREQ'(1) << owner_d;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (req[owner_q]) begin
                    q_d    = owner_data;
                    qbar_d = ~owner_data;
                end
                ptr_d   = owner_q + IDXW'(1);
                state_d = RELEASE;
                busy_d  = 1'b1;
            end
            RELEASE: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign q     = q_q;
    assign qbar  = qbar_q;

endmodule

// File: tb/tb_dreg_share_arbiter.sv
// Directed bench for dreg_share_arbiter with hand-computed expectations.
module tb_dreg_share_arbiter;

    localparam int unsigned WIDTH = 8;

    logic                clk;
    logic                rst;
    logic [3:0]          req;
    logic [4*WIDTH-1:0]  wr_data;
    logic [3:0]          grant;
    logic [1:0]          owner;
    logic                busy;
    logic [WIDTH-1:0]    q;
    logic [WIDTH-1:0]    qbar;

    int checks = 0;
    int errors = 0;

    dreg_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr_data (wr_data),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .q       (q),
        .qbar    (qbar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        wr_data[i*8 +: 8] = d;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_owner"}, 32'(owner), 32'h0);
        chk({tag, "_busy"},  32'(busy),  32'h0);
        chk({tag, "_q"},     32'(q),     32'h00);
        chk({tag, "_qbar"},  32'(qbar),  32'hFF);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        wr_data = '0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk_reset_values("rst");

        // Single handshake on requester 2
        set_data(2, 8'hA5);
        req = 4'b0100;
        tick();
        chk("hs_grant", 32'(grant), 32'h4);
        chk("hs_owner", 32'(owner), 32'd2);
        chk("hs_busy",  32'(busy),  32'd1);
        tick();
        chk("hs_q",     32'(q),     32'hA5);
        chk("hs_qbar",  32'(qbar),  32'h5A);
        chk("hs_gr0",   32'(grant), 32'h0);
        chk("hs_busy2", 32'(busy),  32'd1);
        req = 4'b0000;
        tick();
        chk("hs_idle",  32'(busy),  32'd0);

        // Reset so the pointer is back at 0, then 4-way contention
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int i;
            i = n % 4;
            tick();
            chk($sformatf("rr%0d_grant", n), 32'(grant), 32'(4'b0001 << i));
            chk($sformatf("rr%0d_owner", n), 32'(owner), 32'(i));
            tick();
            chk($sformatf("rr%0d_q", n),     32'(q),     32'h10 + 32'(i));
            chk($sformatf("rr%0d_gr0", n),   32'(grant), 32'h0);
            req[i] = 1'b0;
            tick();
            chk($sformatf("rr%0d_idle", n),  32'(busy),  32'd0);
            chk($sformatf("rr%0d_gidle", n), 32'(grant), 32'h0);
            req = (n == 4) ? 4'b0000 : 4'b1111;
        end

        // Serve requester 3, then req=1001 must go to 0 first, then 3
        req = 4'b1000;
        tick();
        chk("w3_grant", 32'(grant), 32'h8);
        tick();
        chk("w3_q", 32'(q), 32'h13);
        req = 4'b0000;
        tick();
        req = 4'b1001;
        tick();
        chk("wr_grant0", 32'(grant), 32'h1);
        tick();
        chk("wr_q0", 32'(q), 32'h10);
        req = 4'b1000;
        tick();
        chk("wr_idle", 32'(busy), 32'd0);
        tick();
        chk("wr_grant3", 32'(grant), 32'h8);
        chk("wr_owner3", 32'(owner), 32'd3);
        tick();
        chk("wr_q3", 32'(q), 32'h13);
        req = 4'b0000;
        tick();

        // Withdraw during GRANT: no load, pointer still advances to 2
        req = 4'b0010;
        tick();
        chk("wd_grant", 32'(grant), 32'h2);
        req = 4'b0000;
        tick();
        chk("wd_q",    32'(q),    32'h13);
        chk("wd_qbar", 32'(qbar), 32'hEC);
        chk("wd_busy", 32'(busy), 32'd1);
        tick();
        chk("wd_idle", 32'(busy), 32'd0);
        set_data(0, 8'h77);
        req = 4'b0011;
        tick();
        chk("wd_grant0", 32'(grant), 32'h1);
        chk("wd_owner0", 32'(owner), 32'd0);
        tick();
        chk("wd_q0", 32'(q), 32'h77);

        // Long hold: owner 0 keeps req, others ignored, data changes ignored
        for (int c = 0; c < 10; c++) begin
            set_data(0, 8'(c));
            set_data(1, 8'hF0 + 8'(c));
            tick();
            chk($sformatf("hold%0d_busy", c),  32'(busy),  32'd1);
            chk($sformatf("hold%0d_grant", c), 32'(grant), 32'h0);
            chk($sformatf("hold%0d_q", c),     32'(q),     32'h77);
        end

        // Reset during RELEASE
        rst = 1'b1;
        tick();
        chk_reset_values("mrst");
        rst = 1'b0;
        req = 4'b1110;
        tick();
        chk("mrst_grant", 32'(grant), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
